// File: rtl/seg_chase_display.sv
// Multiplexed 7-segment "chasing snake" animator: a trail of lit segments walks a
// perimeter or zigzag path across DIGITS digits while the display is scanned.
module seg_chase_display #(
    parameter int DIGITS    = 6,
    parameter int TRAIL_LEN = 5,
    parameter int STEP_DIV  = 100000,
    parameter int SCAN_DIV  = 2048,
    localparam int SW       = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          dir,
    input  logic          pause,
    output logic [7:0]    segout,
    output logic [SW-1:0] scanout,
    output logic          step_pulse,
    output logic          lap_done
);
    localparam int LP  = 2 * DIGITS + 4;
    localparam int LZ  = 5 * DIGITS;
    localparam int HW  = $clog2(LZ + 1);
    localparam int FW  = $clog2(TRAIL_LEN + 1);
    localparam int STW = $clog2(STEP_DIV);
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] MODE_PER   = 2'd0;
    localparam logic [1:0] MODE_ZIG   = 2'd1;
    localparam logic [1:0] MODE_ALT   = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;
    localparam logic [0:0] PAT_PER    = 1'b0;
    localparam logic [0:0] PAT_ZIG    = 1'b1;

    typedef struct packed {
        logic [SW-1:0] dig;
        logic [7:0]    mask;
    } elem_t;

    logic [1:0]     mode_q;
    logic [0:0]     pat;
    logic [HW-1:0]  head;
    logic [FW-1:0]  fill;
    logic [STW-1:0] sdiv;
    logic [SCW-1:0] scdiv;
    logic [SW-1:0]  scan_idx;

    logic           zig_now;
    logic [HW-1:0]  last;
    logic [HW-1:0]  alt_last;
    logic           step_due;
    logic           wrap;
    logic [HW-1:0]  head_step;
    logic [7:0]     render_seg;

    // Path position s of the trail element i behind (or ahead of, in reverse) head.
    function automatic logic [HW-1:0] trail_pos(input logic [HW-1:0] h, input int i,
                                                 input logic d, input int len);
        int t;
        t = d ? (int'(h) + i) : (int'(h) + 3 * len - i);
        return HW'(t % len);
    endfunction

    function automatic elem_t per_elem(input logic [HW-1:0] s);
        int    si;
        elem_t e;
        si = int'(s);
        e  = '0;
        if (si < DIGITS) begin
            e.dig = SW'(si);           e.mask = 8'h01;
        end else if (si == DIGITS) begin
            e.dig = SW'(DIGITS - 1);   e.mask = 8'h02;
        end else if (si == DIGITS + 1) begin
            e.dig = SW'(DIGITS - 1);   e.mask = 8'h04;
        end else if (si <= 2 * DIGITS + 1) begin
            e.dig = SW'(2 * DIGITS + 1 - si); e.mask = 8'h08;
        end else if (si == 2 * DIGITS + 2) begin
            e.dig = '0;                e.mask = 8'h10;
        end else begin
            e.dig = '0;                e.mask = 8'h20;
        end
        return e;
    endfunction

    // Even digits go a,b,g,e,d; odd digits come back d,c,g,f,a.
    function automatic elem_t zig_elem(input logic [HW-1:0] s);
        int    si;
        int    k;
        int    j;
        elem_t e;
        si    = int'(s);
        k     = si / 5;
        j     = si % 5;
        e.dig = SW'(k);
        if (k % 2 == 0) begin
            case (j)
                0:       e.mask = 8'h01;
                1:       e.mask = 8'h02;
                2:       e.mask = 8'h40;
                3:       e.mask = 8'h10;
                default: e.mask = 8'h08;
            endcase
        end else begin
            case (j)
                0:       e.mask = 8'h08;
                1:       e.mask = 8'h04;
                2:       e.mask = 8'h40;
                3:       e.mask = 8'h20;
                default: e.mask = 8'h01;
            endcase
        end
        return e;
    endfunction

    assign zig_now   = (mode_q == MODE_ZIG) || ((mode_q == MODE_ALT) && (pat == PAT_ZIG));
    assign last      = zig_now ? HW'(LZ - 1) : HW'(LP - 1);
    assign alt_last  = (pat == PAT_PER) ? HW'(LZ - 1) : HW'(LP - 1);
    assign step_due  = (mode_q != MODE_BLANK) && !pause && (sdiv == STW'(STEP_DIV - 1));
    assign wrap      = dir ? (head == '0) : (head == last);
    assign head_step = dir ? ((head == '0) ? last : head - 1'b1)
                           : ((head == last) ? '0 : head + 1'b1);

    always_comb begin
        elem_t e;
        e          = '0;
        render_seg = '0;
        for (int i = 0; i < TRAIL_LEN; i++) begin
            if (i < int'(fill)) begin
                e = zig_now ? zig_elem(trail_pos(head, i, dir, LZ))
                            : per_elem(trail_pos(head, i, dir, LP));
                if (e.dig == scan_idx) render_seg = render_seg | e.mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_PER;
            pat        <= PAT_PER;
            head       <= '0;
            fill       <= FW'(1);
            sdiv       <= '0;
            scdiv      <= '0;
            scan_idx   <= '0;
            segout     <= '0;
            scanout    <= '0;
            step_pulse <= 1'b0;
            lap_done   <= 1'b0;
        end else begin
            // Display registers always sample the pre-edge scan index and head together.
            scanout <= scan_idx;
            segout  <= (mode_q == MODE_BLANK) ? 8'h00 : render_seg;
            if (scdiv == SCW'(SCAN_DIV - 1)) begin
                scdiv    <= '0;
                scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scdiv <= scdiv + 1'b1;
            end

            mode_q     <= mode;
            step_pulse <= 1'b0;
            lap_done   <= 1'b0;
            if (mode != mode_q) begin
                head <= '0;
                fill <= FW'(1);
                sdiv <= '0;
                pat  <= PAT_PER;
            end else if ((mode_q != MODE_BLANK) && !pause) begin
                if (step_due) begin
                    sdiv       <= '0;
                    step_pulse <= 1'b1;
                    lap_done   <= wrap;
                    if (wrap && (mode_q == MODE_ALT)) begin
                        // New pattern starts at its own end when running in reverse.
                        pat  <= ~pat;
                        fill <= FW'(1);
                        head <= dir ? alt_last : '0;
                    end else begin
                        head <= head_step;
                        fill <= (fill == FW'(TRAIL_LEN)) ? fill : fill + 1'b1;
                    end
                end else begin
                    sdiv <= sdiv + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_chase_display.sv
// Bench for seg_chase_display: a path-table reference model predicts every output
// cycle into a queue, and a monitor pops and compares after each clock edge.
module tb_seg_chase_display;
    localparam int DIGITS   = 6;
    localparam int TRAIL    = 5;
    localparam int STEP_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int SW       = 3;
    localparam int W        = 8 + SW + 2;
    localparam int LP       = 2 * DIGITS + 4;
    localparam int LZ       = 5 * DIGITS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic          dir = 1'b0;
    logic          pause = 1'b0;
    logic [7:0]    segout;
    logic [SW-1:0] scanout;
    logic          step_pulse;
    logic          lap_done;

    always #5 clk = ~clk;

    seg_chase_display #(
        .DIGITS(DIGITS), .TRAIL_LEN(TRAIL), .STEP_DIV(STEP_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .dir(dir), .pause(pause),
        .segout(segout), .scanout(scanout), .step_pulse(step_pulse), .lap_done(lap_done)
    );

    int p_dig[LP];
    int p_msk[LP];
    int z_dig[LZ];
    int z_msk[LZ];

    logic [W-1:0] exp_q[$];
    int n_vec   = 0;
    int n_err   = 0;
    int n_steps = 0;
    int n_laps  = 0;
    bit run     = 1'b0;

    int m_mode, m_pat, m_head, m_fill, m_sdiv, m_scdiv, m_scan;

    task automatic build_tables();
        int even_m[5];
        int odd_m[5];
        even_m = '{1, 2, 64, 16, 8};
        odd_m  = '{8, 4, 64, 32, 1};
        for (int s = 0; s < LP; s++) begin
            if (s < DIGITS)                begin p_dig[s] = s;              p_msk[s] = 1;  end
            else if (s == DIGITS)          begin p_dig[s] = DIGITS - 1;     p_msk[s] = 2;  end
            else if (s == DIGITS + 1)      begin p_dig[s] = DIGITS - 1;     p_msk[s] = 4;  end
            else if (s <= 2 * DIGITS + 1)  begin p_dig[s] = 2*DIGITS+1 - s; p_msk[s] = 8;  end
            else if (s == 2 * DIGITS + 2)  begin p_dig[s] = 0;              p_msk[s] = 16; end
            else                           begin p_dig[s] = 0;              p_msk[s] = 32; end
        end
        for (int s = 0; s < LZ; s++) begin
            z_dig[s] = s / 5;
            z_msk[s] = ((s / 5) % 2 == 0) ? even_m[s % 5] : odd_m[s % 5];
        end
    endtask

    function automatic int render(int zig, int head, int fill, int d, int scan);
        int len;
        int seg;
        int s;
        len = zig ? LZ : LP;
        seg = 0;
        for (int i = 0; i < fill; i++) begin
            s = d ? (head + i) % len : ((head - i) % len + len) % len;
            if ((zig ? z_dig[s] : p_dig[s]) == scan) seg = seg | (zig ? z_msk[s] : p_msk[s]);
        end
        return seg;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pat = 0; m_head = 0; m_fill = 1;
        m_sdiv = 0; m_scdiv = 0; m_scan = 0;
    endtask

    // Apply one clock of inputs and predict what the outputs show after that edge.
    task automatic drive(input bit r, input int md, input bit d, input bit p);
        int seg, scan_o, sp, lap, zig, len;
        @(negedge clk);
        reset = r; mode = 2'(md); dir = d; pause = p; run = 1'b1;
        seg = 0; scan_o = 0; sp = 0; lap = 0;
        if (r) begin
            model_reset();
        end else begin
            zig    = (m_mode == 1) || (m_mode == 2 && m_pat == 1);
            seg    = (m_mode == 3) ? 0 : render(zig, m_head, m_fill, d, m_scan);
            scan_o = m_scan;
            if (m_scdiv == SCAN_DIV - 1) begin
                m_scdiv = 0;
                m_scan  = (m_scan + 1) % DIGITS;
            end else begin
                m_scdiv++;
            end
            if (md != m_mode) begin
                m_head = 0; m_fill = 1; m_sdiv = 0; m_pat = 0; m_mode = md;
            end else if (m_mode != 3 && !p) begin
                if (m_sdiv == STEP_DIV - 1) begin
                    m_sdiv = 0;
                    len    = zig ? LZ : LP;
                    sp     = 1;
                    lap    = d ? (m_head == 0) : (m_head == len - 1);
                    m_head = (m_head + (d ? len - 1 : 1)) % len;
                    m_fill = (m_fill < TRAIL) ? m_fill + 1 : TRAIL;
                    if (lap && m_mode == 2) begin
                        m_pat  = 1 - m_pat;
                        m_fill = 1;
                        m_head = d ? ((m_pat == 1) ? LZ : LP) - 1 : 0;
                    end
                end else begin
                    m_sdiv++;
                end
            end
        end
        exp_q.push_back({8'(seg), SW'(scan_o), 1'(sp), 1'(lap)});
    endtask

    task automatic run_phase(input int n, input bit r, input int md, input bit d, input bit p);
        for (int k = 0; k < n; k++) drive(r, md, d, p);
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                n_vec++;
                got = {segout, scanout, step_pulse, lap_done};
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL queue_empty t=%0t got=%h", $time, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL outputs t=%0t got seg=%h scan=%0d step=%b lap=%b expected seg=%h scan=%0d step=%b lap=%b",
                                 $time, got[W-1:SW+2], got[SW+1:2], got[1], got[0],
                                 e[W-1:SW+2], e[SW+1:2], e[1], e[0]);
                    end
                end
                if (step_pulse === 1'b1) n_steps++;
                if (lap_done === 1'b1) n_laps++;
            end
        end
    end

    initial begin : stimulus
        int s0, l0, md, d, p, r;
        build_tables();
        model_reset();
        run_phase(3, 1, 0, 0, 0);

        s0 = n_steps; l0 = n_laps;
        run_phase(64, 0, 0, 0, 0);
        check("perimeter_steps", n_steps - s0, 16);
        check("perimeter_laps", n_laps - l0, 1);

        s0 = n_steps; l0 = n_laps;
        run_phase(121, 0, 1, 0, 0);
        check("zigzag_steps", n_steps - s0, 30);
        check("zigzag_laps", n_laps - l0, 1);

        s0 = n_steps; l0 = n_laps;
        run_phase(185, 0, 2, 0, 0);
        check("alternate_steps", n_steps - s0, 46);
        check("alternate_laps", n_laps - l0, 2);

        run_phase(3, 0, 0, 0, 0);
        s0 = n_steps;
        run_phase(10, 0, 0, 0, 1);
        check("pause_steps", n_steps - s0, 0);
        s0 = n_steps;
        run_phase(2, 0, 0, 0, 0);
        check("resume_steps", n_steps - s0, 1);

        run_phase(1, 0, 1, 0, 0);
        s0 = n_steps; l0 = n_laps;
        run_phase(5, 0, 0, 1, 0);
        check("reverse_steps", n_steps - s0, 1);
        check("reverse_laps", n_laps - l0, 1);

        run_phase(7, 0, 0, 1, 0);
        s0 = n_steps;
        run_phase(20, 0, 3, 1, 0);
        check("blank_steps", n_steps - s0, 0);

        run_phase(2, 1, 1, 0, 0);
        run_phase(40, 0, 1, 0, 0);

        md = 2; d = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 59) == 0) md = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) d = 1 - d;
            p = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 199) == 0);
            drive(r[0], md, d[0], p[0]);
        end
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
